// File: rtl/alu1_rr_arbiter.sv
// alu1_rr_arbiter: round-robin sharing of one combinational Alu1 between NREQ requesters.
// Define ALU1_ARB_PERF_CNT_EN to add the grant_cnt/stall_cyc performance counters.
module alu1_rr_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ),
    parameter int ALU1_CMD_WIDTH = 4,
    parameter logic [ALU1_CMD_WIDTH-1:0] ALU1_NR_COMMANDS = 8,
    parameter logic [ALU1_CMD_WIDTH-1:0] ALU1_OP_TRANSFER = 0
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef ALU1_ARB_PERF_CNT_EN
    output logic [NREQ*32-1:0]             grant_cnt,
    output logic [31:0]                    stall_cyc,
`endif
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*ALU1_CMD_WIDTH-1:0] req_cmd,
    input  logic [NREQ*WIDTH-1:0]          req_in1,
    input  logic [NREQ*WIDTH-1:0]          req_in2,
    output logic [ALU1_CMD_WIDTH-1:0]      alu_cmd,
    output logic [WIDTH-1:0]               alu_in1,
    output logic [WIDTH-1:0]               alu_in2,
    input  logic [WIDTH-1:0]               alu_out,
    input  logic                           alu_co,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [WIDTH-1:0]               rsp_out,
    output logic                           rsp_co,
    output logic                           rsp_err
);
    localparam int CW = ALU1_CMD_WIDTH;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;

    logic [ID_W-1:0]  last, win, hi, lo;
    logic             hi_found, any, open, accept, sel_err, err_q;
    logic [CW-1:0]    sel_cmd;
    logic [WIDTH-1:0] sel_in1, sel_in2;

    // hi: lowest valid index above last; lo: lowest valid overall (the wrap-around case)
    always_comb begin
        hi = '0;
        lo = '0;
        hi_found = 1'b0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && ID_W'(i) > last) begin
                hi = ID_W'(i);
                hi_found = 1'b1;
            end
            if (req_valid[i]) begin
                lo = ID_W'(i);
                any = 1'b1;
            end
        end
        win = hi_found ? hi : lo;
    end

    always_comb begin
        sel_cmd = '0;
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_cmd = req_cmd[i*CW +: CW];
                sel_in1 = req_in1[i*WIDTH +: WIDTH];
                sel_in2 = req_in2[i*WIDTH +: WIDTH];
            end
        end
    end

    assign open      = state == IDLE || (state == RESP && rsp_ready);
    assign accept    = open && any;
    assign req_ready = accept ? NREQ'(1) << win : '0;
    assign sel_err   = sel_cmd >= ALU1_NR_COMMANDS;
    assign rsp_valid = state == RESP;

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = EXEC;
        else if (state == EXEC)
            state_nx = RESP;
        else if (state == RESP && rsp_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= ID_W'(NREQ - 1);
            alu_cmd <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            err_q   <= 1'b0;
            rsp_id  <= '0;
            rsp_out <= '0;
            rsp_co  <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_cmd <= sel_err ? ALU1_OP_TRANSFER : sel_cmd;
                alu_in1 <= sel_in1;
                alu_in2 <= sel_in2;
                err_q   <= sel_err;
                rsp_id  <= win;
                last    <= win;
            end
            if (state == EXEC) begin
                rsp_out <= err_q ? '0 : alu_out;
                rsp_co  <= !err_q && alu_co;
                rsp_err <= err_q;
            end
        end
    end

`ifdef ALU1_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cyc <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i] && grant_cnt[i*32 +: 32] != '1)
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
            if (rsp_valid && !rsp_ready && stall_cyc != '1)
                stall_cyc <= stall_cyc + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu1_rr_arbiter.sv
// tb_alu1_rr_arbiter: directed checks of alu1_rr_arbiter against a small Alu1 model.
module tb_alu1_rr_arbiter;
    localparam int W = 64;
    localparam int N = 4;
    localparam logic [3:0] TRANSFER = 4'd0, ADD = 4'd1, SUB = 4'd2, INC = 4'd3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*4-1:0] req_cmd;
    logic [N*W-1:0] req_in1, req_in2;
    logic [3:0]     alu_cmd;
    logic [W-1:0]   alu_in1, alu_in2, alu_out;
    logic           alu_co;
    logic           rsp_valid, rsp_ready, rsp_co, rsp_err;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_out;
`ifdef ALU1_ARB_PERF_CNT_EN
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     stall_cyc;
`endif
    int checks = 0;
    int errors = 0;

    alu1_rr_arbiter dut (
        .clk(clk), .rst(rst),
`ifdef ALU1_ARB_PERF_CNT_EN
        .grant_cnt(grant_cnt), .stall_cyc(stall_cyc),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_in1(req_in1), .req_in2(req_in2),
        .alu_cmd(alu_cmd), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_co(rsp_co), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Alu1 stand-in: unknown commands pass in1 through
    always_comb begin
        {alu_co, alu_out} = {1'b0, alu_in1};
        if (alu_cmd == ADD)
            {alu_co, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
        else if (alu_cmd == SUB)
            {alu_co, alu_out} = {alu_in1 < alu_in2, alu_in1 - alu_in2};
        else if (alu_cmd == INC)
            {alu_co, alu_out} = {1'b0, alu_in1} + 65'd1;
    end

    typedef struct {
        int         id;
        logic [3:0] cmd;
        logic [W-1:0] in1, in2, exp_out;
        logic       exp_co, exp_err;
        logic [3:0] exp_alu_cmd;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[id] = 1'b1;
        req_cmd[id*4 +: 4] = cmd;
        req_in1[id*W +: W] = a;
        req_in2[id*W +: W] = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2, ADD, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, ADD};
        vecs[1] = '{1, INC, '1, 64'd0, 64'd0, 1'b1, 1'b0, INC};
        vecs[2] = '{3, 4'd8, 64'd99, 64'd1, 64'd0, 1'b0, 1'b1, TRANSFER};
        vecs[3] = '{0, SUB, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, SUB};
        vecs[4] = '{1, 4'd15, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, TRANSFER};
        vecs[5] = '{3, TRANSFER, 64'hdead, 64'd0, 64'hdead, 1'b0, 1'b0, TRANSFER};
        vecs[6] = '{0, ADD, '1, 64'd1, 64'd0, 1'b1, 1'b0, ADD};

        rst = 1'b1; req_valid = '0; req_cmd = '0; req_in1 = '0; req_in2 = '0; rsp_ready = 1'b1;
        repeat (3) step;
        rst = 1'b0;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_out", rsp_out, 0);
        chk("rst_co", rsp_co, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_alu", {alu_cmd, alu_in1, alu_in2}, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].id, vecs[k].cmd, vecs[k].in1, vecs[k].in2);
            @(negedge clk);
            chk("v_grant", req_ready, W'(1) << vecs[k].id);
            step;
            req_valid = '0;
            chk("v_exec_valid", rsp_valid, 0);
            chk("v_alu_cmd", alu_cmd, vecs[k].exp_alu_cmd);
            chk("v_alu_in1", alu_in1, vecs[k].in1);
            step;
            chk("v_valid", rsp_valid, 1);
            chk("v_id", rsp_id, W'(vecs[k].id));
            chk("v_out", rsp_out, vecs[k].exp_out);
            chk("v_co", rsp_co, vecs[k].exp_co);
            chk("v_err", rsp_err, vecs[k].exp_err);
        end
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;

        for (int i = 0; i < N; i++) drive(i, TRANSFER, W'(i), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, W'(1) << (k % N));
            step;
            chk("rr_exec_valid", rsp_valid, 0);
            @(negedge clk);
            chk("rr_exec_ready", req_ready, 0);
            step;
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, W'(k % N));
            chk("rr_out", rsp_out, W'(k % N));
        end
        req_valid = '0;
        step;

        rsp_ready = 1'b0;
        drive(1, ADD, 64'd1, 64'd1);
        @(negedge clk);
        chk("bp_grant", req_ready, 64'b0010);
        step;
        req_valid = '0;
        step;
        drive(3, ADD, 64'd20, 64'd22);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_out", rsp_out, 2);
            step;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", req_ready, 64'b1000);
        step;
        req_valid = '0;
        chk("bp_exec_valid", rsp_valid, 0);
        step;
        chk("bp_valid", rsp_valid, 1);
        chk("bp_id", rsp_id, 3);
        chk("bp_out", rsp_out, 42);
`ifdef ALU1_ARB_PERF_CNT_EN
        chk("perf_stall", stall_cyc, 5);
        chk("perf_grant", grant_cnt, {32'd3, 32'd2, 32'd3, 32'd2});
`endif

        for (int i = 0; i < N; i++) drive(i, TRANSFER, W'(16 + i), 64'd0);
        @(negedge clk);
        chk("mr_grant0", req_ready, 64'b0001);
        step;
        step;
        @(negedge clk);
        chk("mr_grant1", req_ready, 64'b0010);
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mr_valid_after_rst", rsp_valid, 0);
`ifdef ALU1_ARB_PERF_CNT_EN
        chk("mr_perf", {grant_cnt, stall_cyc}, 0);
`endif
        @(negedge clk);
        chk("mr_first_grant", req_ready, 64'b0001);
        step;
        chk("mr_exec_valid", rsp_valid, 0);
        step;
        chk("mr_valid", rsp_valid, 1);
        chk("mr_id", rsp_id, 0);
        chk("mr_out", rsp_out, 16);
        req_valid = '0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
